// File: rtl/wb_dma_writer_pkg.sv
// Shared encodings for the Wishbone DMA writer: FSM states and Wishbone
// cycle-type / burst-type constants.
package wb_dma_writer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_DATA,
    S_BURST,
    S_RETRY_WAIT,
    S_FINISH
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_dma_writer_burst_sizer.sv
// Burst length calculator: the smallest of the burst cap, the words still
// to move, and the words left before the next 4 KiB page boundary.
module wb_burst_sizer #(
  parameter int BURST_LEN = 8
) (
  input  logic [15:0] remaining,
  input  logic [9:0]  word_ofs,
  output logic [4:0]  beats
);

  logic [10:0] to_boundary;

  // word_ofs is the word index inside the current 4 KiB page
  assign to_boundary = 11'd1024 - {1'b0, word_ofs};

  always_comb begin
    beats = 5'(BURST_LEN);
    if (to_boundary < 11'(BURST_LEN)) beats = to_boundary[4:0];
    if (remaining < 16'(beats)) beats = remaining[4:0];
  end

endmodule

// File: rtl/wb_dma_writer.sv
// Wishbone master that drains a FWFT source FIFO into PCI memory space with
// incrementing bursts, retry back-off and error abort.
module wb_dma_writer
  import wb_dma_writer_pkg::*;
#(
  parameter int BURST_LEN   = 8,
  parameter int RETRY_GAP   = 4,
  parameter int RETRY_LIMIT = 15
) (
  input  logic        WB_CLK,
  input  logic        WB_RST,
  input  logic        START,
  input  logic [31:0] DST_ADDR,
  input  logic [15:0] WORD_COUNT,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERROR,
  input  logic [31:0] SRC_DATA,
  input  logic [9:0]  SRC_LEVEL,
  output logic        SRC_READ,
  output logic [31:0] WBM_ADR_O,
  output logic [31:0] WBM_DAT_O,
  output logic [3:0]  WBM_SEL_O,
  output logic        WBM_CYC_O,
  output logic        WBM_STB_O,
  output logic        WBM_WE_O,
  output logic [2:0]  WBM_CTI_O,
  output logic [1:0]  WBM_BTE_O,
  input  logic        WBM_ACK_I,
  input  logic        WBM_RTY_I,
  input  logic        WBM_ERR_I
);

  localparam int RTY_W = $clog2(RETRY_LIMIT + 2);
  localparam int GAP_W = (RETRY_GAP > 1) ? $clog2(RETRY_GAP) : 1;

  state_t             state, state_nx;
  logic [29:0]        word_addr;
  logic [15:0]        remaining;
  logic [4:0]         beats;
  logic [4:0]         beat_cnt;
  logic               single;
  logic [RTY_W-1:0]   retry_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               error;
  logic               in_burst, level_ok, retry_exhausted;
  logic               take_ack, take_rty, take_err;
  logic               addr_lsb_unused;

  // byte-lane bits of the destination are not meaningful for word transfers
  assign addr_lsb_unused = ^DST_ADDR[1:0];

  wb_burst_sizer #(.BURST_LEN(BURST_LEN)) u_sizer (
    .remaining (remaining),
    .word_ofs  (word_addr[9:0]),
    .beats     (beats)
  );

  assign in_burst        = (state == S_BURST);
  assign level_ok        = (SRC_LEVEL >= {5'd0, beats});
  assign retry_exhausted = (retry_cnt == RTY_W'(RETRY_LIMIT));

  // termination priority is ERR > RTY > ACK; an over-limit retry becomes an error
  assign take_err = in_burst && (WBM_ERR_I || (WBM_RTY_I && retry_exhausted));
  assign take_rty = in_burst && !WBM_ERR_I && WBM_RTY_I && !retry_exhausted;
  assign take_ack = in_burst && !WBM_ERR_I && !WBM_RTY_I && WBM_ACK_I;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:       if (START) state_nx = (WORD_COUNT == 16'd0) ? S_FINISH : S_WAIT_DATA;
      S_WAIT_DATA:  if (level_ok) state_nx = S_BURST;
      S_BURST: begin
        if (take_err)      state_nx = S_FINISH;
        else if (take_rty) state_nx = S_RETRY_WAIT;
        else if (take_ack && beat_cnt == 5'd1)
          state_nx = (remaining == 16'd1) ? S_FINISH : S_WAIT_DATA;
      end
      S_RETRY_WAIT: if (gap_cnt == '0) state_nx = level_ok ? S_BURST : S_WAIT_DATA;
      S_FINISH:     state_nx = S_IDLE;
      default:      state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge WB_CLK) begin
    if (WB_RST) begin
      state     <= S_IDLE;
      beat_cnt  <= '0;
      single    <= 1'b0;
      retry_cnt <= '0;
      gap_cnt   <= '0;
      error     <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && START) begin
        error     <= 1'b0;
        retry_cnt <= '0;
      end
      // beat count is captured on every entry to BURST, including reissues
      if (state != S_BURST && state_nx == S_BURST) begin
        beat_cnt <= beats;
        single   <= (beats == 5'd1);
      end else if (take_ack) begin
        beat_cnt <= beat_cnt - 5'd1;
      end
      if (take_ack) begin
        retry_cnt <= '0;
      end else if (take_rty) begin
        retry_cnt <= retry_cnt + 1'b1;
        gap_cnt   <= GAP_W'(RETRY_GAP - 1);
      end
      if (state == S_RETRY_WAIT && gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      if (take_err) error <= 1'b1;
    end
  end

  always_ff @(posedge WB_CLK) begin
    if (state == S_IDLE && START) begin
      word_addr <= DST_ADDR[31:2];
      remaining <= WORD_COUNT;
    end else if (take_ack) begin
      word_addr <= word_addr + 30'd1;
      remaining <= remaining - 16'd1;
    end
  end

  assign WBM_CYC_O = in_burst;
  assign WBM_STB_O = in_burst;
  assign WBM_WE_O  = in_burst;
  assign WBM_SEL_O = in_burst ? 4'hF : 4'h0;
  assign WBM_ADR_O = in_burst ? {word_addr, 2'b00} : 32'd0;
  assign WBM_DAT_O = in_burst ? SRC_DATA : 32'd0;
  assign WBM_BTE_O = BTE_LINEAR;
  assign WBM_CTI_O = (!in_burst || single) ? CTI_CLASSIC :
                     (beat_cnt == 5'd1)    ? CTI_EOB : CTI_INCR;

  assign SRC_READ = take_ack;
  assign BUSY     = (state != S_IDLE);
  assign DONE     = (state == S_FINISH);
  assign ERROR    = error;

endmodule

// File: tb/tb_wb_dma_writer.sv
// Scoreboard bench for wb_dma_writer: a bus/FIFO responder drives the DUT and
// a monitor compares every cycle against a transfer-level reference model.
module tb_wb_dma_writer;

  localparam int BURST_LEN   = 8;
  localparam int RETRY_GAP   = 4;
  localparam int RETRY_LIMIT = 15;

  logic        clk, rst, start, busy, done, error, src_read;
  logic [31:0] dst_addr, src_data;
  logic [15:0] word_count;
  logic [9:0]  src_level;
  logic [31:0] wbm_adr, wbm_dat;
  logic [3:0]  wbm_sel;
  logic        wbm_cyc, wbm_stb, wbm_we, wbm_ack, wbm_rty, wbm_err;
  logic [2:0]  wbm_cti;
  logic [1:0]  wbm_bte;

  wb_dma_writer #(.BURST_LEN(BURST_LEN), .RETRY_GAP(RETRY_GAP), .RETRY_LIMIT(RETRY_LIMIT)) dut (
    .WB_CLK(clk), .WB_RST(rst), .START(start), .DST_ADDR(dst_addr), .WORD_COUNT(word_count),
    .BUSY(busy), .DONE(done), .ERROR(error), .SRC_DATA(src_data), .SRC_LEVEL(src_level),
    .SRC_READ(src_read), .WBM_ADR_O(wbm_adr), .WBM_DAT_O(wbm_dat), .WBM_SEL_O(wbm_sel),
    .WBM_CYC_O(wbm_cyc), .WBM_STB_O(wbm_stb), .WBM_WE_O(wbm_we), .WBM_CTI_O(wbm_cti),
    .WBM_BTE_O(wbm_bte), .WBM_ACK_I(wbm_ack), .WBM_RTY_I(wbm_rty), .WBM_ERR_I(wbm_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {M_ACK, M_RTY_AT, M_ERR_AT, M_RTY_ALL, M_RAND} mode_t;
  typedef enum int {PH_IDLE, PH_DECIDE, PH_HOLD, PH_BURST, PH_FIN} ph_t;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] fifo[$];
  logic [31:0] sb_q[$];
  int          avail = 0;
  int          pops = 0;
  bit          pend_pop = 0;
  bit          rst_req = 1;
  bit          fired = 0;
  mode_t       mode = M_ACK;
  int          param = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int exp_len(input int unsigned a, input int rem);
    int b, l;
    b = (4096 - int'(a % 4096)) / 4;
    l = BURST_LEN;
    if (rem < l) l = rem;
    if (b < l) l = b;
    return l;
  endfunction

  // ---------------- responder: FIFO model and Wishbone slave ----------------
  task automatic cycle(input bit st, input logic [31:0] dst, input logic [15:0] cnt, input bit spur);
    @(negedge clk);
    if (pend_pop) begin
      if (fifo.size() > 0) void'(fifo.pop_front());
      pops++;
      if (avail > 0) avail--;
    end
    rst = rst_req;
    start = st;
    if (st) begin
      dst_addr = dst;
      word_count = cnt;
    end else if (spur && busy && ($urandom_range(0, 15) == 0)) begin
      start = 1'b1;
      dst_addr = $urandom;
      word_count = 16'($urandom);
    end
    wbm_ack = 1'b0; wbm_rty = 1'b0; wbm_err = 1'b0;
    if (wbm_stb) begin
      case (mode)
        M_ACK:     wbm_ack = 1'b1;
        M_RTY_AT:  if (pops == param && !fired) begin wbm_rty = 1'b1; fired = 1; end
                   else wbm_ack = 1'b1;
        M_ERR_AT:  if (pops == param) wbm_err = 1'b1; else wbm_ack = 1'b1;
        M_RTY_ALL: wbm_rty = 1'b1;
        default: begin
          wbm_ack = ($urandom_range(0, 3) != 0);
          wbm_rty = ($urandom_range(0, 7) == 0);
          wbm_err = ($urandom_range(0, 63) == 0);
        end
      endcase
    end
    src_data = (fifo.size() > 0) ? fifo[0] : 32'h0;
    src_level = 10'(avail);
    #1 pend_pop = src_read;
  endtask

  task automatic run_xfer(input logic [31:0] dst, input int cnt, input mode_t m, input int p,
                          input int avail0, input int starve, input bit spur);
    int n;
    logic [31:0] w;
    fifo.delete();
    pops = 0; fired = 0; mode = m; param = p;
    for (int i = 0; i < cnt; i++) begin
      w = $urandom;
      fifo.push_back(w);
      sb_q.push_back(w);
    end
    avail = avail0;
    cycle(1'b1, dst, 16'(cnt), 1'b0);
    n = 0;
    do begin
      cycle(1'b0, 32'h0, 16'h0, spur);
      n++;
      if (n == starve) avail = fifo.size();
    end while ((busy || n < 2) && n < 3000);
    if (n >= 3000) begin
      vectors++; miscompares++;
      $display("FAIL xfer_timeout: busy still %0b after %0d cycles, expected 0", busy, n);
    end
    repeat (3) cycle(1'b0, 32'h0, 16'h0, 1'b0);
  endtask

  // ---------------- monitor: reference model and scoreboard ----------------
  ph_t         ph = PH_IDLE;
  int unsigned m_addr = 0;
  int          m_rem = 0, m_blen = 0, m_bidx = 0, m_hold = 0, m_rty = 0, m_pops = 0;
  bit          m_err = 0, rst_seen = 0;

  task automatic decide();
    int l;
    l = exp_len(m_addr, m_rem);
    if (int'(src_level) >= l) begin
      ph = PH_BURST; m_blen = l; m_bidx = 0;
    end else begin
      ph = PH_DECIDE;
    end
  endtask

  always @(negedge clk) begin
    logic [2:0] e_cti;
    #2;
    if (rst) begin
      ph = PH_IDLE; m_err = 0; m_rty = 0; rst_seen = 1;
      sb_q.delete();
    end else begin
      if (rst_seen) begin
        chk("rst_cyc", 32'(wbm_cyc), 32'd0);
        chk("rst_read", 32'(src_read), 32'd0);
        chk("rst_adr", wbm_adr, 32'd0);
        chk("rst_sel", 32'(wbm_sel), 32'd0);
        rst_seen = 0;
      end
      if (ph != PH_BURST) begin
        chk("stb_idle", 32'(wbm_stb), 32'd0);
        chk("read_idle", 32'(src_read), 32'd0);
      end
      chk("done", 32'(done), 32'(ph == PH_FIN));
      chk("busy", 32'(busy), 32'(ph != PH_IDLE));
      chk("error", 32'(error), 32'(m_err));
      case (ph)
        PH_IDLE: if (start) begin
          m_addr = dst_addr & 32'hFFFF_FFFC;
          m_rem = int'(word_count);
          m_err = 0; m_rty = 0; m_pops = 0;
          ph = (m_rem == 0) ? PH_FIN : PH_DECIDE;
        end
        PH_FIN: begin
          chk("pops", 32'(pops), 32'(m_pops));
          sb_q.delete();
          ph = PH_IDLE;
        end
        PH_DECIDE: decide();
        PH_HOLD: if (m_hold < RETRY_GAP) m_hold++; else decide();
        default: begin
          e_cti = (m_blen == 1) ? 3'b000 : (m_bidx == m_blen - 1) ? 3'b111 : 3'b010;
          chk("stb", 32'(wbm_stb), 32'd1);
          chk("cyc", 32'(wbm_cyc), 32'd1);
          chk("we", 32'(wbm_we), 32'd1);
          chk("sel", 32'(wbm_sel), 32'hF);
          chk("bte", 32'(wbm_bte), 32'd0);
          chk("adr", wbm_adr, m_addr);
          chk("cti", 32'(wbm_cti), 32'(e_cti));
          if (sb_q.size() == 0) chk("sb_underflow", 32'd0, 32'd1);
          else chk("dat", wbm_dat, sb_q[0]);
          if (wbm_err) begin
            chk("read_err", 32'(src_read), 32'd0);
            m_err = 1; ph = PH_FIN;
          end else if (wbm_rty) begin
            chk("read_rty", 32'(src_read), 32'd0);
            m_rty++;
            if (m_rty > RETRY_LIMIT) begin m_err = 1; ph = PH_FIN; end
            else begin ph = PH_HOLD; m_hold = 1; end
          end else if (wbm_ack) begin
            chk("read_ack", 32'(src_read), 32'd1);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
            m_addr += 4; m_rem--; m_pops++; m_rty = 0; m_bidx++;
            if (m_bidx == m_blen) ph = (m_rem == 0) ? PH_FIN : PH_DECIDE;
          end else begin
            chk("read_wait", 32'(src_read), 32'd0);
          end
        end
      endcase
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] d;
    rst = 1'b1; start = 1'b0; dst_addr = '0; word_count = '0;
    src_data = '0; src_level = '0; wbm_ack = 1'b0; wbm_rty = 1'b0; wbm_err = 1'b0;
    repeat (3) cycle(1'b0, 32'h0, 16'h0, 1'b0);
    rst_req = 0;
    repeat (2) cycle(1'b0, 32'h0, 16'h0, 1'b0);

    run_xfer(32'h0000_1000, 8, M_ACK,     0, 8, 0, 1'b0);  // single burst
    run_xfer(32'h0000_1000, 8, M_RTY_AT,  3, 8, 0, 1'b0);  // retry on 4th beat
    run_xfer(32'h0000_1000, 8, M_ERR_AT,  1, 8, 0, 1'b0);  // error on beat 2
    run_xfer(32'h0000_1FF8, 8, M_ACK,     0, 8, 0, 1'b0);  // 4 KiB crossing
    run_xfer(32'h0000_1FFC, 3, M_ACK,     0, 3, 0, 1'b0);  // single-beat burst first
    run_xfer(32'h0000_3000, 8, M_ACK,     0, 3, 10, 1'b0); // starvation
    run_xfer(32'h0000_4000, 8, M_RTY_ALL, 0, 8, 0, 1'b0);  // retry limit
    run_xfer(32'h0000_5002, 0, M_ACK,     0, 0, 0, 1'b0);  // zero count
    run_xfer(32'h0000_6001, 20, M_ACK,    0, 20, 0, 1'b1); // ignored STARTs

    // reset in the middle of a burst
    fifo.delete(); pops = 0; mode = M_ACK; avail = 20;
    for (int i = 0; i < 20; i++) begin d = $urandom; fifo.push_back(d); sb_q.push_back(d); end
    cycle(1'b1, 32'h0000_7000, 16'd20, 1'b0);
    repeat (4) cycle(1'b0, 32'h0, 16'h0, 1'b0);
    rst_req = 1;
    cycle(1'b0, 32'h0, 16'h0, 1'b0);
    rst_req = 0;
    fifo.delete(); avail = 0; pend_pop = 0;
    repeat (3) cycle(1'b0, 32'h0, 16'h0, 1'b0);
    run_xfer(32'h0000_7000, 5, M_ACK, 0, 5, 0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      int c;
      d = $urandom;
      d[11:0] = 12'hFFF - 12'($urandom_range(0, 120));
      c = $urandom_range(1, 40);
      run_xfer(d, c, M_RAND, 0, $urandom_range(0, c), $urandom_range(1, 20), 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
